// File: rtl/sdram_frame_reader.sv
// Avalon-MM read master streaming one frame buffer from SDRAM through a credit-limited pixel FIFO.
// Optional FRAME_LOOP_EN: continuous frame refresh, wrapping to the base address without a new start.
module sdram_frame_reader #(
   parameter int                      ADDRESSWIDTH = 32,
   parameter int                      DATAWIDTH    = 32,
   parameter logic [ADDRESSWIDTH-1:0] BASE_ADDR    = 32'h0800_0000,
   parameter int                      FRAME_WORDS  = 307200,
   parameter int                      FIFO_DEPTH   = 64
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    start,
   output logic                    busy,
   output logic                    done,
   output logic [ADDRESSWIDTH-1:0] master_address,
   output logic                    master_read,
   input  logic [DATAWIDTH-1:0]    master_readdata,
   input  logic                    master_readdatavalid,
   input  logic                    master_waitrequest,
   output logic [DATAWIDTH-1:0]    pix_data,
   output logic                    pix_valid,
   input  logic                    pix_ready
);

   localparam int IW = $clog2(FRAME_WORDS + 1);
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   localparam logic [IW-1:0]           LAST_IDX  = IW'(FRAME_WORDS - 1);
   localparam logic [IW-1:0]           ISSUE_ONE = IW'(1);
   localparam logic [CW-1:0]           CNT_ONE   = CW'(1);
   localparam logic [CW:0]             DEPTH_C   = (CW + 1)'(FIFO_DEPTH);
   localparam logic [PW-1:0]           PTR_ONE   = PW'(1);
   localparam logic [ADDRESSWIDTH-1:0] ADDR_STEP = ADDRESSWIDTH'(4);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t                  state_r, state_s;
   logic [IW-1:0]           issued_r, issued_s;
   logic [ADDRESSWIDTH-1:0] addr_r, addr_s;
   logic                    read_r, read_s;
   logic                    busy_r, busy_s;
   logic                    done_r, done_s;
   logic [CW-1:0]           in_flight_r, in_flight_s;
   logic [CW-1:0]           count_r, count_s;

   logic [DATAWIDTH-1:0]    mem_r [FIFO_DEPTH];
   logic [PW-1:0]           wr_ptr_r, rd_ptr_r;
   logic [DATAWIDTH-1:0]    head_r;
   logic                    head_valid_r, head_valid_s;

   logic accept_s, push_s, pop_s, start_ok_s;
   logic stored_empty_s, load_head_s, from_mem_s, bypass_s, write_mem_s;

`ifdef FRAME_LOOP_EN
   logic [IW-1:0] popped_r, popped_s;
`endif

   assign accept_s       = read_r & ~master_waitrequest;
   assign push_s         = master_readdatavalid & (state_r != ST_IDLE);
   assign pop_s          = head_valid_r & pix_ready;
   assign start_ok_s     = start & (state_r == ST_IDLE) & ~done_r;

   // The head register is the FIFO output; the array only holds words queued behind it.
   assign stored_empty_s = (wr_ptr_r == rd_ptr_r);
   assign load_head_s    = ~head_valid_r | pop_s;
   assign from_mem_s     = load_head_s & ~stored_empty_s;
   assign bypass_s       = load_head_s & stored_empty_s & push_s;
   assign write_mem_s    = push_s & ~bypass_s;

   assign busy           = busy_r;
   assign done           = done_r;
   assign master_address = addr_r;
   assign master_read    = read_r;
   assign pix_data       = head_r;
   assign pix_valid      = head_valid_r;

   // Next-value of the outstanding-read credit and total FIFO occupancy (head included).
   always_comb begin
      in_flight_s = in_flight_r;
      count_s     = count_r;
      case ({accept_s, push_s})
         2'b10:   in_flight_s = in_flight_r + CNT_ONE;
         2'b01:   in_flight_s = in_flight_r - CNT_ONE;
         default: in_flight_s = in_flight_r;
      endcase
      case ({push_s, pop_s})
         2'b10:   count_s = count_r + CNT_ONE;
         2'b01:   count_s = count_r - CNT_ONE;
         default: count_s = count_r;
      endcase
   end

   // Head-valid next value: refill from the array, bypass a fresh return, or go empty.
   always_comb begin
      head_valid_s = head_valid_r;
      if (load_head_s) begin
         head_valid_s = ~stored_empty_s | push_s;
      end else begin
         head_valid_s = 1'b1;
      end
   end

   // Frame control FSM: next state, address/issue counters, busy/done and read request.
   always_comb begin
      state_s  = state_r;
      issued_s = issued_r;
      addr_s   = addr_r;
      busy_s   = busy_r;
      done_s   = 1'b0;
      read_s   = 1'b0;
`ifdef FRAME_LOOP_EN
      popped_s = popped_r;
`endif
      case (state_r)
         ST_IDLE: begin
            if (start_ok_s) begin
               state_s  = ST_READ;
               busy_s   = 1'b1;
               issued_s = {IW{1'b0}};
               addr_s   = BASE_ADDR;
            end else begin
               state_s  = ST_IDLE;
            end
         end
         ST_READ: begin
            if (accept_s) begin
               if (issued_r == LAST_IDX) begin
`ifdef FRAME_LOOP_EN
                  addr_s   = BASE_ADDR;
                  issued_s = {IW{1'b0}};
`else
                  addr_s   = addr_r + ADDR_STEP;
                  issued_s = issued_r + ISSUE_ONE;
                  state_s  = ST_DRAIN;
`endif
               end else begin
                  addr_s   = addr_r + ADDR_STEP;
                  issued_s = issued_r + ISSUE_ONE;
               end
            end else begin
               state_s = ST_READ;
            end
         end
         ST_DRAIN: begin
            if ((in_flight_s == {CW{1'b0}}) && (count_s == {CW{1'b0}})) begin
               state_s = ST_IDLE;
               busy_s  = 1'b0;
               done_s  = 1'b1;
               addr_s  = BASE_ADDR;
            end else begin
               state_s = ST_DRAIN;
            end
         end
         default: begin
            state_s = ST_IDLE;
            busy_s  = 1'b0;
         end
      endcase

`ifdef FRAME_LOOP_EN
      // Continuous mode marks each frame boundary by counting pixels leaving the stream.
      if (pop_s) begin
         if (popped_r == LAST_IDX) begin
            popped_s = {IW{1'b0}};
            done_s   = 1'b1;
         end else begin
            popped_s = popped_r + ISSUE_ONE;
            done_s   = 1'b0;
         end
      end else begin
         popped_s = popped_r;
         done_s   = 1'b0;
      end
`endif

      // A stalled request is held unchanged; otherwise issue only while credit remains.
      if (read_r && master_waitrequest) begin
         read_s = 1'b1;
      end else if (state_s == ST_READ) begin
         read_s = (({1'b0, in_flight_s} + {1'b0, count_s}) < DEPTH_C);
      end else begin
         read_s = 1'b0;
      end
   end

   // Control and credit registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r     <= ST_IDLE;
         issued_r    <= {IW{1'b0}};
         addr_r      <= BASE_ADDR;
         read_r      <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         in_flight_r <= {CW{1'b0}};
         count_r     <= {CW{1'b0}};
`ifdef FRAME_LOOP_EN
         popped_r    <= {IW{1'b0}};
`endif
      end else begin
         state_r     <= state_s;
         issued_r    <= issued_s;
         addr_r      <= addr_s;
         read_r      <= read_s;
         busy_r      <= busy_s;
         done_r      <= done_s;
         in_flight_r <= in_flight_s;
         count_r     <= count_s;
`ifdef FRAME_LOOP_EN
         popped_r    <= popped_s;
`endif
      end
   end

   // FIFO pointers and registered head.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_r     <= {PW{1'b0}};
         rd_ptr_r     <= {PW{1'b0}};
         head_r       <= {DATAWIDTH{1'b0}};
         head_valid_r <= 1'b0;
      end else begin
         head_valid_r <= head_valid_s;
         if (write_mem_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (from_mem_s) begin
            head_r   <= mem_r[rd_ptr_r];
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end else if (bypass_s) begin
            head_r   <= master_readdata;
         end
      end
   end

   // Array payload; validity is tracked by the pointers, so no reset is needed.
   always_ff @(posedge clk) begin
      if (write_mem_s) begin
         mem_r[wr_ptr_r] <= master_readdata;
      end
   end

endmodule
